dma_ctrl_mc: RTL and testbench

//  Multi-channel DMA controller; parametrised successor to the single-channel dma block.

---
 rtl/dma_ctrl_mc.sv | 129 ++++++++++++
 tb/tb_dma_ctrl_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl_mc.sv
// dma_ctrl_mc: round-robin multi-channel DMA, each transfer moved in slices of BURST words.
// Latency: begin_dma -> br two cycles later (latch, ARB); mtoe follows bg combinationally in XFER.
// Backpressure: word held until mem_signal; bg loss parks in REQ. `DMA_CYCLE_STEAL_EN releases bus per burst.
module dma_ctrl_mc #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_CH    = 2,
    parameter int BURST     = 4,
    parameter int IDX_W     = 6
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic [NUM_CH-1:0]                              begin_dma,
    input  logic [NUM_CH*WORD_SIZE-1:0]                    length,
    input  logic [NUM_CH*WORD_SIZE-1:0]                    target_address,
    input  logic                                           bg,
    input  logic                                           mem_signal,
    output logic                                           br,
    output logic                                           mtoe,
    output logic [WORD_SIZE-1:0]                           memory_address,
    output logic [IDX_W-1:0]                               index,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic [NUM_CH-1:0]                              dma_end
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W = $clog2(BURST + 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST - 1);

    typedef enum logic [2:0] {IDLE, ARB, REQ, XFER, DONE, REL} state_t;

    state_t               state;
    logic [NUM_CH-1:0]    pending;
    logic [CH_W-1:0]      rr;
    logic [BC_W-1:0]      bcnt;
    logic [WORD_SIZE-1:0] len_q [NUM_CH];
    logic [WORD_SIZE-1:0] tgt_q [NUM_CH];
    logic [WORD_SIZE-1:0] off_q [NUM_CH];

    logic [NUM_CH-1:0]    new_req, zero_req, done_clr, pend_nxt;
    logic [CH_W-1:0]      pick, ch_inc;
    logic [WORD_SIZE-1:0] off_inc;

    always_comb begin
        new_req  = '0;
        zero_req = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            new_req[c]  = begin_dma[c] && !pending[c] && (length[c*WORD_SIZE +: WORD_SIZE] != '0);
            zero_req[c] = begin_dma[c] && !pending[c] && (length[c*WORD_SIZE +: WORD_SIZE] == '0);
        end
        done_clr = (state == DONE) ? (NUM_CH'(1) << ch_sel) : '0;
        pend_nxt = (pending & ~done_clr) | new_req;
        off_inc  = off_q[ch_sel] + WORD_SIZE'(1);
        ch_inc   = (32'(ch_sel) == NUM_CH - 1) ? '0 : ch_sel + CH_W'(1);
        // Scan downward so the nearest pending channel at/after rr wins.
        pick = rr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[(int'(rr) + i) % NUM_CH])
                pick = CH_W'((int'(rr) + i) % NUM_CH);
        end
    end

    assign mtoe           = (state == XFER) && bg;
    assign memory_address = (state == XFER) ? tgt_q[ch_sel] + off_q[ch_sel] : '0;
    assign index          = (state == XFER) ? off_q[ch_sel][IDX_W-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            rr      <= '0;
            bcnt    <= '0;
            br      <= 1'b0;
            ch_sel  <= '0;
            dma_end <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                len_q[c] <= '0;
                tgt_q[c] <= '0;
                off_q[c] <= '0;
            end
        end else begin
            dma_end <= zero_req;
            pending <= pend_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                if (new_req[c]) begin
                    len_q[c] <= length[c*WORD_SIZE +: WORD_SIZE];
                    tgt_q[c] <= target_address[c*WORD_SIZE +: WORD_SIZE];
                    off_q[c] <= '0;
                end
            end
            case (state)
                IDLE: if (|(pending | new_req)) state <= ARB;
                ARB: begin
                    ch_sel <= pick;
                    bcnt   <= '0;
                    br     <= 1'b1;
                    state  <= REQ;
                end
                REQ: if (bg) state <= XFER;
                XFER: begin
                    // A word presented while bg is low is never counted.
                    if (!bg) begin
                        state <= REQ;
                    end else if (mem_signal) begin
                        off_q[ch_sel] <= off_inc;
                        if (off_inc == len_q[ch_sel]) begin
                            state           <= DONE;
                            br              <= 1'b0;
                            dma_end[ch_sel] <= 1'b1;
                        end else if (bcnt == BURST_LAST) begin
                            bcnt <= '0;
`ifdef DMA_CYCLE_STEAL_EN
                            state <= REL;
                            br    <= 1'b0;
                            rr    <= ch_inc;
`endif
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
                end
                DONE: begin
                    rr    <= ch_inc;
                    state <= (|pend_nxt) ? ARB : IDLE;
                end
                REL:     state <= ARB;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_ctrl_mc.sv
// Directed bench for dma_ctrl_mc: single/dual channel transfers, zero length, bg loss, reset abort, wrap.
module tb_dma_ctrl_mc;
    localparam int WS  = 16;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH-1:0]    begin_dma = '0;
    logic [NCH*WS-1:0] length = '0;
    logic [NCH*WS-1:0] target_address = '0;
    logic              bg = 1'b0;
    logic              mem_signal = 1'b0;
    logic              br, mtoe;
    logic [WS-1:0]     memory_address;
    logic [5:0]        index;
    logic [0:0]        ch_sel;
    logic [NCH-1:0]    dma_end;

    int checks = 0;
    int failures = 0;
    logic [WS-1:0] addr_log[$];
    int idx_log[$];
    int ch_log[$];
    int end_log[$];
    logic acc;
    logic [WS-1:0] exp3_addr [9];
    int exp3_ch [9];
    int exp3_end [2];
    logic [WS-1:0] exp6_addr [4];

    dma_ctrl_mc dut (
        .clk(clk), .reset_n(reset_n), .begin_dma(begin_dma), .length(length),
        .target_address(target_address), .bg(bg), .mem_signal(mem_signal), .br(br),
        .mtoe(mtoe), .memory_address(memory_address), .index(index), .ch_sel(ch_sel),
        .dma_end(dma_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qi(input int i);
        return (i < idx_log.size()) ? 32'(idx_log[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qc(input int i);
        return (i < ch_log.size()) ? 32'(ch_log[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qe(input int i);
        return (i < end_log.size()) ? 32'(end_log[i]) : 32'hDEAD_BEEF;
    endfunction

    // Memory-side responder; called on a negedge, returns on the negedge after the last expected dma_end.
    task automatic run(input bit every2, input int drop_at, input int exp_ends);
        int  cyc = 0;
        int  ends = 0;
        int  hold = 0;
        bit  phase = 1'b0;
        bit  dropped = 1'b0;
        addr_log.delete(); idx_log.delete(); ch_log.delete(); end_log.delete();
        while (ends < exp_ends && cyc < 300) begin
            for (int c = 0; c < NCH; c++) begin
                if (dma_end[c]) begin
                    end_log.push_back(c);
                    ends++;
                end
            end
            if (drop_at >= 0 && !dropped && addr_log.size() == drop_at && mtoe) begin
                bg = 1'b0;
                mem_signal = 1'b1;
                #1;
                chk("drop_mtoe_low", 32'(mtoe), 32'd0);
                chk("drop_br_held", 32'(br), 32'd1);
                dropped = 1'b1;
                hold = 3;
            end else if (hold > 0) begin
                mem_signal = 1'b0;
                chk("regrant_wait_br", 32'(br), 32'd1);
                hold--;
                if (hold == 0) bg = 1'b1;
            end else if (mtoe) begin
                phase = every2 ? !phase : 1'b1;
                mem_signal = phase;
                if (phase) begin
                    addr_log.push_back(memory_address);
                    idx_log.push_back(int'(index));
                    ch_log.push_back(int'(ch_sel));
                end
            end else begin
                mem_signal = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        mem_signal = 1'b0;
        chk("run_end_count", 32'(ends), 32'(exp_ends));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; bg = 1'b0; begin_dma = '0; mem_signal = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
`ifdef DMA_CYCLE_STEAL_EN
        exp3_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0200, 16'h0201, 16'h0202, 16'h0104, 16'h0105};
        exp3_ch   = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
        exp3_end  = '{1, 0};
`else
        exp3_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0200, 16'h0201, 16'h0202};
        exp3_ch   = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        exp3_end  = '{0, 1};
`endif
        exp6_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        // Reset state
        #2;
        chk("rst_br", 32'(br), 32'd0);
        chk("rst_mtoe", 32'(mtoe), 32'd0);
        chk("rst_addr", 32'(memory_address), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_ch_sel", 32'(ch_sel), 32'd0);
        chk("rst_dma_end", 32'(dma_end), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: ch0 len=12 at 0x01F4, bg immediate, mem_signal every 2nd cycle
        @(negedge clk);
        length[0 +: WS] = 16'd12; target_address[0 +: WS] = 16'h01F4; bg = 1'b1; begin_dma = 2'b01;
        @(negedge clk);
        begin_dma = '0;
        chk("t1_arb_br", 32'(br), 32'd0);
        @(negedge clk);
        chk("t1_req_br", 32'(br), 32'd1);
        chk("t1_req_mtoe", 32'(mtoe), 32'd0);
        run(1'b1, -1, 1);
        chk("t1_br_low_after", 32'(br), 32'd0);
        chk("t1_words", 32'(addr_log.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t1_addr%0d", i), qa(i), 32'h01F4 + 32'(i));
            chk($sformatf("t1_idx%0d", i), qi(i), 32'(i));
        end
        chk("t1_end_ch", qe(0), 32'd0);

        // 2: zero length on ch1
        @(negedge clk);
        length[WS +: WS] = 16'd0; begin_dma = 2'b10;
        @(negedge clk);
        begin_dma = '0;
        chk("t2_end_pulse", 32'(dma_end), 32'b10);
        chk("t2_br_idle", 32'(br), 32'd0);
        @(negedge clk);
        chk("t2_end_clear", 32'(dma_end), 32'd0);
        acc = 1'b0;
        repeat (4) begin
            acc = acc | br;
            @(negedge clk);
        end
        chk("t2_no_br", 32'(acc), 32'd0);

        // 3: both channels begun together from a fresh round-robin pointer
        do_reset();
        @(negedge clk);
        length = {16'd3, 16'd6}; target_address = {16'h0200, 16'h0100}; bg = 1'b1; begin_dma = 2'b11;
        @(negedge clk);
        begin_dma = '0;
        run(1'b0, -1, 2);
        chk("t3_words", 32'(addr_log.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t3_addr%0d", i), qa(i), 32'(exp3_addr[i]));
            chk($sformatf("t3_ch%0d", i), qc(i), 32'(exp3_ch[i]));
        end
        chk("t3_first_end", qe(0), 32'(exp3_end[0]));
        chk("t3_second_end", qe(1), 32'(exp3_end[1]));

        // 4: bg lost after the 2nd word of a 4-word transfer
        @(negedge clk);
        length[0 +: WS] = 16'd4; target_address[0 +: WS] = 16'h0300; bg = 1'b1; begin_dma = 2'b01;
        @(negedge clk);
        begin_dma = '0;
        run(1'b0, 2, 1);
        chk("t4_words", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_addr%0d", i), qa(i), 32'h0300 + 32'(i));

        // 5: asynchronous reset mid-burst
        @(negedge clk);
        length[0 +: WS] = 16'd8; target_address[0 +: WS] = 16'h0400; bg = 1'b1; begin_dma = 2'b01;
        @(negedge clk);
        begin_dma = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_first_addr", 32'(memory_address), 32'h0400);
        mem_signal = 1'b1;
        @(negedge clk);
        chk("t5_second_addr", 32'(memory_address), 32'h0401);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_br", 32'(br), 32'd0);
        chk("t5_rst_mtoe", 32'(mtoe), 32'd0);
        chk("t5_rst_addr", 32'(memory_address), 32'd0);
        chk("t5_rst_index", 32'(index), 32'd0);
        chk("t5_rst_ch_sel", 32'(ch_sel), 32'd0);
        mem_signal = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        acc = 1'b0;
        repeat (6) begin
            acc = acc | br | mtoe | (|dma_end);
            @(negedge clk);
        end
        chk("t5_quiet_after_reset", 32'(acc), 32'd0);

        // 6: address wraps past 0xFFFF
        length[0 +: WS] = 16'd4; target_address[0 +: WS] = 16'hFFFE; bg = 1'b1; begin_dma = 2'b01;
        @(negedge clk);
        begin_dma = '0;
        run(1'b0, -1, 1);
        chk("t6_words", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_addr%0d", i), qa(i), 32'(exp6_addr[i]));
            chk($sformatf("t6_idx%0d", i), qi(i), 32'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
